mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit with the architectural HI/LO registers. It sits beside the combinational ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, and stalls the pipeline via oBusy.
- Services MTHI/MTLO writes. oHi/oLo feed MFHI/MFLO directly.

---
 rtl/mul_div_unit.sv | 94 +++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers
// iClk/iRst_n: clock, async active-low reset
// iStart/iOp/iA/iB: launch an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
// iHiWe/iLoWe/iWData: MTHI/MTLO writes, honoured only while idle with no start
// oBusy/oDone: stall while iterating; one-cycle pulse when HI/LO take a result
// oHi/oLo: architectural HI/LO
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [1:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iHiWe,
  input  logic             iLoWe,
  input  logic [WIDTH-1:0] iWData,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_p, neg_r, done, sgn, ge;
  logic [WIDTH-1:0] m, acc_hi, acc_lo, hi, lo, a_mag, b_mag, diff;
  logic [WIDTH:0] sum, shifted;
  logic [2*WIDTH-1:0] prod_fix;
  assign sgn = ~iOp[0];
  assign a_mag = (sgn && iA[WIDTH-1]) ? -iA : iA;
  assign b_mag = (sgn && iB[WIDTH-1]) ? -iB : iB;
  // acc_hi:acc_lo is the product (multiplier shifts out of acc_lo) or remainder:quotient.
  // Divide by zero needs no special path for HI: every trial subtract of 0 succeeds,
  // so the remainder ends as |iA| and the sign fix restores the original dividend.
  always_comb begin
    sum = {1'b0, acc_hi} + {1'b0, m};
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge = shifted >= {1'b0, m};
    diff = shifted[WIDTH-1:0] - m;
    prod_fix = neg_p ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && iStart) state_nx = RUN;
    else if (state == RUN && cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
    else if (state == FIX) state_nx = IDLE;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
      done <= 1'b0;
      m <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      done <= state == FIX;
      if (state == IDLE && iStart) begin
        is_div <= iOp[1];
        m <= iOp[1] ? b_mag : a_mag;
        acc_hi <= '0;
        acc_lo <= iOp[1] ? a_mag : b_mag;
        neg_p <= sgn & (iA[WIDTH-1] ^ iB[WIDTH-1]);
        neg_r <= sgn & iA[WIDTH-1];
        cnt <= '0;
      end else if (state == IDLE) begin
        if (iHiWe) hi <= iWData;
        if (iLoWe) lo <= iWData;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (is_div) {acc_hi, acc_lo} <= {ge ? diff : shifted[WIDTH-1:0], acc_lo[WIDTH-2:0], ge};
        else {acc_hi, acc_lo} <= acc_lo[0] ? {sum, acc_lo[WIDTH-1:1]} : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
      end else if (is_div) begin
        lo <= (m == '0) ? '1 : neg_p ? -acc_lo : acc_lo;
        hi <= neg_r ? -acc_hi : acc_hi;
      end else begin
        {hi, lo} <= prod_fix;
      end
    end
  end
  assign oBusy = state != IDLE;
  assign oDone = done;
  assign oHi = hi;
  assign oLo = lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against a behavioural model
module tb_mul_div_unit;
  logic iClk = 1'b0;
  logic iRst_n, iStart, iHiWe, iLoWe, oBusy, oDone;
  logic [1:0] iOp;
  logic [31:0] iA, iB, iWData, oHi, oLo;
  logic [63:0] sb_q[$];
  int checks = 0;
  int failures = 0;

  mul_div_unit dut (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iHiWe(iHiWe), .iLoWe(iLoWe), .iWData(iWData),
    .oBusy(oBusy), .oDone(oDone), .oHi(oHi), .oLo(oLo)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] sp;
    sa = a;
    sb = b;
    if (op == 2'b00) begin
      sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return sp;
    end
    if (op == 2'b01) return {32'b0, a} * {32'b0, b};
    if (b == 32'h0) return {a, 32'hFFFFFFFF};
    if (op == 2'b11) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    return {sa % sb, sa / sb};
  endfunction

  // Called just after a falling edge; returns on the falling edge where oDone should be high.
  // mode 1: MTHI mid-run, 2: second iStart mid-run, 3: MTHI/MTLO on the start edge.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int mode);
    logic [31:0] prev_hi, prev_lo;
    logic [63:0] want;
    bit hold_bad, done_bad;
    int n;
    prev_hi = oHi;
    prev_lo = oLo;
    hold_bad = 0;
    done_bad = 0;
    sb_q.push_back(exp);
    iStart = 1'b1;
    iOp = op;
    iA = a;
    iB = b;
    if (mode == 3) begin
      iHiWe = 1'b1;
      iLoWe = 1'b1;
      iWData = 32'hDEADBEEF;
    end
    @(negedge iClk);
    iStart = 1'b0;
    iHiWe = 1'b0;
    iLoWe = 1'b0;
    n = 0;
    while (oBusy === 1'b1 && n < 100) begin
      n++;
      if (oHi !== prev_hi || oLo !== prev_lo) hold_bad = 1;
      if (oDone !== 1'b0) done_bad = 1;
      if (n == 1) begin
        iOp = ~op;
        iA = $urandom;
        iB = $urandom;
      end
      if (n == 5 && mode == 1) begin
        iHiWe = 1'b1;
        iWData = 32'h5A5A5A5A;
      end
      if (n == 5 && mode == 2) begin
        iStart = 1'b1;
        iOp = 2'b01;
        iA = 32'h12345678;
        iB = 32'h9ABCDEF0;
      end
      if (n == 6) begin
        iHiWe = 1'b0;
        iStart = 1'b0;
      end
      @(negedge iClk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " hold"}, 64'(hold_bad), 64'd0);
    check({tag, " no_early_done"}, 64'(done_bad), 64'd0);
    check({tag, " done"}, 64'(oDone), 64'd1);
    want = sb_q.pop_front();
    check({tag, " hi"}, 64'(oHi), 64'(want[63:32]));
    check({tag, " lo"}, 64'(oLo), 64'(want[31:0]));
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    bit seen_done;
    iRst_n = 1'b0;
    iStart = 1'b0;
    iOp = 2'b00;
    iA = '0;
    iB = '0;
    iHiWe = 1'b0;
    iLoWe = 1'b0;
    iWData = '0;
    repeat (2) @(negedge iClk);
    check("reset busy", 64'(oBusy), 64'd0);
    check("reset done", 64'(oDone), 64'd0);
    check("reset hi", 64'(oHi), 64'd0);
    check("reset lo", 64'(oLo), 64'd0);
    iRst_n = 1'b1;
    @(negedge iClk);
    iLoWe = 1'b1;
    iWData = 32'h1234;
    @(negedge iClk);
    iLoWe = 1'b0;
    check("mtlo lo", 64'(oLo), 64'h1234);
    check("mtlo hi untouched", 64'(oHi), 64'd0);
    iHiWe = 1'b1;
    iLoWe = 1'b1;
    iWData = 32'hAAAA5555;
    @(negedge iClk);
    iHiWe = 1'b0;
    iLoWe = 1'b0;
    check("mthi+mtlo hi", 64'(oHi), 64'hAAAA5555);
    check("mthi+mtlo lo", 64'(oLo), 64'hAAAA5555);
    run_op("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 0);
    @(negedge iClk);
    check("done one cycle", 64'(oDone), 64'd0);
    run_op("mult -3*7", 2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 0);
    run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
    run_op("div overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 0);
    run_op("div -5/0", 2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 0);
    run_op("mthi dropped", 2'b01, 32'd3, 32'd4, 64'h00000000_0000000C, 1);
    run_op("restart ignored", 2'b11, 32'd1000, 32'd10, 64'h00000000_00000064, 2);
    run_op("start beats mt", 2'b00, 32'd2, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, 3);
    run_op("back to back", 2'b11, 32'd7, 32'd7, 64'h00000000_00000001, 0);
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb), 0);
    end
    iStart = 1'b1;
    iOp = 2'b11;
    iA = 32'h0000FFFF;
    iB = 32'd3;
    @(negedge iClk);
    iStart = 1'b0;
    repeat (9) @(negedge iClk);
    check("abort busy before", 64'(oBusy), 64'd1);
    iRst_n = 1'b0;
    #1;
    check("abort busy", 64'(oBusy), 64'd0);
    check("abort hi", 64'(oHi), 64'd0);
    check("abort lo", 64'(oLo), 64'd0);
    @(negedge iClk);
    iRst_n = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(negedge iClk);
      if (oDone === 1'b1) seen_done = 1;
    end
    check("abort no done", 64'(seen_done), 64'd0);
    check("abort idle", 64'(oBusy), 64'd0);
    run_op("after abort", 2'b01, 32'd6, 32'd7, 64'h00000000_0000002A, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
